fixed_point_requantizer: RTL
============================

FIXED_POINT_REQUANTIZER -- requirements
Module: fixed_point_requantizer

Interface
REQ-001 SHALL have parameter IN_BITS, default 16: total input width.
REQ-002 SHALL have parameter IN_FRAC, default 8: input fractional bits.
REQ-003 SHALL have parameter OUT_BITS, default 8: total output width.
REQ-004 SHALL have parameter OUT_FRAC, default 4: output fractional bits.
REQ-005 SHALL have parameter IS_SIGNED, default 1: 1 = two's complement, 0 = unsigned.
REQ-006 SHALL have parameter ROUND_EN, default 1: 1 = round half up, 0 = truncate toward minus infinity.
REQ-007 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port in_data, input, IN_BITS: fixed-point sample.
REQ-010 SHALL have port in_valid, input, 1: in_data is valid.
REQ-011 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-012 SHALL have port out_data, output, OUT_BITS: requantized sample.
REQ-013 SHALL have port out_valid, output, 1: out_data is valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts.
REQ-015 SHALL have port out_sat, output, 1: the current out_data was clamped.
REQ-016 SHALL have port sat_count, output, 16: number of clamped samples delivered.
REQ-017 SHALL have port clear_count, input, 1: synchronous clear of sat_count.

Function
REQ-018 SHALL be a 2-stage pipeline: stage 1 aligns and rounds, stage 2 saturates and registers the output; latency SHALL be 2 cycles with no stalls.
REQ-019 SHALL define advance = !out_valid || out_ready; both stages SHALL load only when advance = 1, and in_ready SHALL equal advance.
REQ-020 SHALL accept a sample only on in_valid && in_ready, and SHALL propagate stage valid bits with the data, so that no sample is dropped or duplicated under any out_ready pattern.
REQ-021 SHALL hold out_data, out_sat and out_valid stable while out_valid && !out_ready.
REQ-022 Alignment: when OUT_FRAC >= IN_FRAC, SHALL left-shift by OUT_FRAC-IN_FRAC with zero fill and apply no rounding.
REQ-023 Alignment: when OUT_FRAC < IN_FRAC, with ROUND_EN = 1 SHALL add 2^(IN_FRAC-OUT_FRAC-1) and then arithmetic-shift right by IN_FRAC-OUT_FRAC; with ROUND_EN = 0 SHALL only shift.
REQ-024 SHALL size the intermediate value at max(IN_BITS, OUT_BITS)+|OUT_FRAC-IN_FRAC|+2 bits, sign-extended when IS_SIGNED, so that the rounding carry and shift never overflow.
REQ-025 Saturation: when IS_SIGNED = 1, SHALL clamp to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1]; when IS_SIGNED = 0, SHALL clamp to [0, 2^OUT_BITS-1].
REQ-026 SHALL set out_sat to 1 exactly when clamping changed the value.
REQ-027 SHALL increment sat_count on each handshake with out_valid && out_ready && out_sat, and sat_count SHALL stop at 0xFFFF without wrapping.
REQ-028 When clear_count coincides with an increment, clear SHALL win and sat_count SHALL be 0 on the next cycle.

Reset
REQ-029 On reset, out_valid and the stage-1 valid bit SHALL be 0, and out_data, out_sat and sat_count SHALL be 0.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight samples, and the first sample after reset release SHALL appear after exactly 2 cycles.
REQ-031 While reset = 1, in_ready SHALL read 1, since out_valid is 0.

Structure
REQ-032 SHALL place the shared package fixed_point_pkg, holding the ROUND_HALF_UP/TRUNCATE constants and the width-calculation constant functions, alongside the other fixed-point blocks.
REQ-033 SHALL use one sub-module, fixed_point_saturate, which is combinational: wide value in, clamped value and saturation flag out, and is instantiated in stage 2.

Verification (16-bit Q8.8 signed in, 8-bit Q4.4 signed out unless noted)
REQ-034 Input 0x0128 (1.15625) with ROUND_EN = 1 SHALL give out_data 0x13 and out_sat 0; with ROUND_EN = 0 it SHALL give 0x12.
REQ-035 Input 0xFFF8 (-0.03125) SHALL give 0x00; input 0x5230 SHALL give 0x7F with out_sat 1; input 0xB000 SHALL give 0x80 with out_sat 1.
REQ-036 A stream of 8 samples with out_ready toggling 1010... SHALL deliver all 8 in order with no loss, and in_ready SHALL be 0 whenever out_valid && !out_ready.
REQ-037 With sat_count preset to 0xFFFE by stimulus, three saturating samples SHALL leave sat_count at 0xFFFF; clear_count asserted together with a fourth saturating sample SHALL leave sat_count at 0.
REQ-038 Reset pulsed while two samples are in flight SHALL drop both; the next sample after release SHALL produce out_valid exactly 2 cycles later.
REQ-039 With IS_SIGNED = 0 and unsigned Q8.8 input 0xFF80 (255.5), out_data SHALL be 0xFF with out_sat 1.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared constants and width helpers for the fixed-point datapath blocks.
// Rounding mode encodings and intermediate-width calculation live here.
package fixed_point_pkg;

    localparam int unsigned ROUND_HALF_UP = 1;
    localparam int unsigned TRUNCATE      = 0;
    localparam int unsigned SAT_CNT_W     = 16;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned abs_diff(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Wide enough that the rounding carry and the alignment shift cannot overflow.
    function automatic int unsigned inter_width(input int unsigned in_bits,
                                                input int unsigned out_bits,
                                                input int unsigned in_frac,
                                                input int unsigned out_frac);
        return max_u(in_bits, out_bits) + abs_diff(in_frac, out_frac) + 2;
    endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// Combinational clamp of a wide signed intermediate into OUT_BITS,
// flagging whenever the clamp altered the value.
module fixed_point_saturate
    import fixed_point_pkg::*;
#(
    parameter int unsigned W         = 28,
    parameter int unsigned OUT_BITS  = 8,
    parameter int unsigned IS_SIGNED = 1
) (
    input  logic signed [W-1:0]        wide_in,
    output logic        [OUT_BITS-1:0] clamped,
    output logic                       sat_flag
);

    logic upper_ones_c;
    logic upper_zeros_c;

    // Signed fits iff the bits above the output sign all copy it; unsigned iff they are all zero.
    always_comb begin
        clamped       = wide_in[OUT_BITS-1:0];
        sat_flag      = 1'b0;
        upper_ones_c  = &wide_in[W-1:OUT_BITS-1];
        upper_zeros_c = ~|wide_in[W-1:OUT_BITS-1];
        if (IS_SIGNED != 0) begin
            if (!(upper_ones_c || upper_zeros_c)) begin
                sat_flag = 1'b1;
                clamped  = wide_in[W-1] ? {1'b1, {(OUT_BITS-1){1'b0}}}
                                        : {1'b0, {(OUT_BITS-1){1'b1}}};
            end
        end else begin
            if (|wide_in[W-1:OUT_BITS]) begin
                sat_flag = 1'b1;
                clamped  = wide_in[W-1] ? '0 : '1;
            end
        end
    end

endmodule

// File: rtl/fixed_point_requantizer.sv
// Two-stage fixed-point requantizer: stage 1 aligns/rounds, stage 2 saturates
// and holds the output under a ready/valid handshake; counts clamped deliveries.
module fixed_point_requantizer
    import fixed_point_pkg::*;
#(
    parameter int unsigned IN_BITS   = 16,
    parameter int unsigned IN_FRAC   = 8,
    parameter int unsigned OUT_BITS  = 8,
    parameter int unsigned OUT_FRAC  = 4,
    parameter int unsigned IS_SIGNED = 1,
    parameter int unsigned ROUND_EN  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_BITS-1:0]   in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_BITS-1:0]  out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sat,
    output logic [SAT_CNT_W-1:0] sat_count,
    input  logic                 clear_count
);

    localparam int unsigned W       = inter_width(IN_BITS, OUT_BITS, IN_FRAC, OUT_FRAC);
    localparam int unsigned SHIFT   = abs_diff(IN_FRAC, OUT_FRAC);
    localparam bit          UPSHIFT = (OUT_FRAC >= IN_FRAC);
    localparam int unsigned RND_POS = (SHIFT == 0) ? 0 : SHIFT - 1;
    localparam logic signed [W-1:0] RND_C = W'(1) << RND_POS;

    logic                 advance_c;
    logic signed [W-1:0]  ext_c;
    logic signed [W-1:0]  aligned_c;
    logic [OUT_BITS-1:0]  sat_data_c;
    logic                 sat_flag_c;

    logic signed [W-1:0]  s1_data_q,  s1_data_d;
    logic                 s1_valid_q, s1_valid_d;
    logic [OUT_BITS-1:0]  out_data_q, out_data_d;
    logic                 out_sat_q,  out_sat_d;
    logic                 out_valid_q, out_valid_d;
    logic [SAT_CNT_W-1:0] sat_count_q, sat_count_d;

    assign advance_c = !out_valid_q || out_ready;

    // Stage 1 datapath: extend, then align to the output binary point.
    always_comb begin
        if (IS_SIGNED != 0) begin
            ext_c = W'($signed(in_data));
        end else begin
            ext_c = W'(in_data);
        end
        aligned_c = ext_c;
        if (UPSHIFT) begin
            aligned_c = ext_c <<< SHIFT;
        end else begin
            if (ROUND_EN != TRUNCATE) begin
                aligned_c = ext_c + RND_C;
            end
            aligned_c = aligned_c >>> SHIFT;
        end
    end

    fixed_point_saturate #(
        .W         (W),
        .OUT_BITS  (OUT_BITS),
        .IS_SIGNED (IS_SIGNED)
    ) u_saturate (
        .wide_in  (s1_data_q),
        .clamped  (sat_data_c),
        .sat_flag (sat_flag_c)
    );

    // Next-state for both pipeline stages and the saturation counter.
    always_comb begin
        s1_data_d   = s1_data_q;
        s1_valid_d  = s1_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        sat_count_d = sat_count_q;

        if (advance_c) begin
            s1_valid_d  = in_valid;
            out_valid_d = s1_valid_q;
            if (in_valid) begin
                s1_data_d = aligned_c;
            end
            if (s1_valid_q) begin
                out_data_d = sat_data_c;
                out_sat_d  = sat_flag_c;
            end
        end

        // Clear takes priority over a coincident increment.
        if (clear_count) begin
            sat_count_d = '0;
        end else if (out_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + SAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data_q   <= '0;
            s1_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_data_q   <= s1_data_d;
            s1_valid_q  <= s1_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign in_ready  = advance_c;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign out_valid = out_valid_q;
    assign sat_count = sat_count_q;

endmodule
